// File: rtl/mem_pkg.sv
// Shared definitions for the memory access stage.
//   SZ_BYTE/SZ_HALF/SZ_WORD : req_size encodings (2'b11 decodes as word)
//   state_e                 : access FSM states
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for the memory access stage.
//   size_i        : access size (SZ_BYTE/SZ_HALF/SZ_WORD, 2'b11 as word)
//   is_unsigned_i : zero-extend loads when 1, sign-extend when 0
//   a_i           : byte offset within the word, already aligned by the caller
//   wdata_i       : right-aligned store data
//   rdata_raw_i   : word read from the RAM
//   sel_o         : little-endian byte-lane enables
//   din_o         : store data replicated across lanes
//   rdata_ext_o   : load data shifted down by 8*a_i, masked and extended
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        is_unsigned_i,
  input  logic [1:0]  a_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_raw_i,
  output logic [3:0]  sel_o,
  output logic [31:0] din_o,
  output logic [31:0] rdata_ext_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted     = rdata_raw_i >> {a_i, 3'b000};
    sel_o       = 4'b1111;
    din_o       = wdata_i;
    rdata_ext_o = shifted;
    case (size_i)
      SZ_BYTE: begin
        sel_o       = 4'b0001 << a_i;
        din_o       = {4{wdata_i[7:0]}};
        rdata_ext_o = is_unsigned_i ? {24'h000000, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        sel_o       = a_i[1] ? 4'b1100 : 4'b0011;
        din_o       = {2{wdata_i[15:0]}};
        rdata_ext_o = is_unsigned_i ? {16'h0000, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        sel_o       = 4'b1111;
        din_o       = wdata_i;
        rdata_ext_o = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: IDLE -> ACCESS -> RESP, one request in flight.
// Build option: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses raise resp_exc, suppress the write,
//               and return 0
//   undefined : resp_exc is always 0 and low address bits are forced aligned
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   req_*                      : request handshake and fields (captured in IDLE)
//   resp_*                     : registered response, held until resp_ready
//   ram_addr/din/we/sel/ld     : RAM control, active only in ACCESS
//   ram_dout                   : combinational RAM read data
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_exc,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  output logic [3:0]        ram_sel,
  output logic              ram_ld,
  input  logic [31:0]       ram_dout
);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_exc_q, resp_exc_d;

  logic [1:0]          a_raw, a_eff;
  logic                misalign;
  logic [3:0]          lane_sel;
  logic [31:0]         lane_din, lane_rdata;

  // Address bits above the RAM window are ignored (accesses wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign a_raw = addr_q[1:0];

  always_comb begin
`ifdef MEM_MISALIGN_TRAP_EN
    a_eff    = a_raw;
    misalign = ((size_q == SZ_HALF) && a_raw[0]) || (size_q[1] && (a_raw != 2'b00));
`else
    misalign = 1'b0;
    a_eff    = a_raw;
    if (size_q == SZ_HALF) a_eff = {a_raw[1], 1'b0};
    else if (size_q[1])    a_eff = 2'b00;
`endif
  end

  mem_lane_align u_lane_align (
    .size_i        (size_q),
    .is_unsigned_i (uns_q),
    .a_i           (a_eff),
    .wdata_i       (wdata_q),
    .rdata_raw_i   (ram_dout),
    .sel_o         (lane_sel),
    .din_o         (lane_din),
    .rdata_ext_o   (lane_rdata)
  );

  // RAM side: quiet outside ACCESS; the write is also gated by reset so an
  // access aborted by reset never commits.
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_sel  = '0;
    ram_ld   = 1'b0;
    ram_we   = 1'b0;
    if (state_q == StAccess) begin
      ram_addr = addr_q[ADDR_W+1:2];
      ram_din  = lane_din;
      ram_sel  = lane_sel;
      ram_ld   = ~we_q;
      ram_we   = we_q & ~misalign & rst_n;
    end
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_exc_d   = resp_exc_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          state_d = StAccess;
        end
      end
      StAccess: begin
        resp_exc_d   = misalign;
        resp_rdata_d = (!we_q && !misalign) ? lane_rdata : 32'h0000_0000;
        state_d      = StResp;
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_exc_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_exc_q   <= resp_exc_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = resp_rdata_q;
  assign resp_exc   = resp_exc_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a 32-word byte-lane RAM model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic        ram_ld;
  logic [31:0] ram_dout;

  logic [31:0] mem [32] = '{default: '0};

  int n_total = 0;
  int n_pass  = 0;

  logic [3:0]  o_sel;
  logic [31:0] o_din;
  logic        o_we;
  logic [31:0] o_rd;
  logic        o_exc;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_exc     (resp_exc),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_we       (ram_we),
    .ram_sel      (ram_sel),
    .ram_ld       (ram_ld),
    .ram_dout     (ram_dout)
  );

  assign ram_dout = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_we) begin
      for (int k = 0; k < 4; k++) begin
        if (ram_sel[k]) mem[ram_addr][8*k +: 8] <= ram_din[8*k +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One full transaction with resp_ready held high; records ACCESS/RESP outputs.
  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd);
    int guard;
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    o_sel = ram_sel; o_din = ram_din; o_we = ram_we;
    @(negedge clk);
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    o_rd = resp_rdata; o_exc = resp_exc;
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_exc", {31'd0, resp_exc}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);

    // SW / LW word
    xact(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF);
    check("sw_sel", {28'd0, o_sel}, 32'hF);
    check("sw_we", {31'd0, o_we}, 32'd1);
    check("sw_rdata0", o_rd, 32'h0);
    xact(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    check("lw_sel", {28'd0, o_sel}, 32'hF);
    check("lw_rdata", o_rd, 32'hDEADBEEF);
    check("lw_exc", {31'd0, o_exc}, 32'd0);

    // Byte store/load at lane 3
    xact(1'b1, 2'b00, 1'b0, 32'h0B, 32'h000000F0);
    check("sb_sel", {28'd0, o_sel}, 32'h8);
    check("sb_din", o_din, 32'hF0F0F0F0);
    xact(1'b0, 2'b00, 1'b0, 32'h0B, 32'h0);
    check("lb_rdata", o_rd, 32'hFFFFFFF0);
    xact(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0);
    check("lbu_rdata", o_rd, 32'h000000F0);
    xact(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    check("lw_after_sb", o_rd, 32'hF0ADBEEF);

    // Half store/load at upper half
    xact(1'b1, 2'b01, 1'b0, 32'h1E, 32'h00008001);
    check("sh_sel", {28'd0, o_sel}, 32'hC);
    check("sh_din", o_din, 32'h80018001);
    xact(1'b0, 2'b01, 1'b0, 32'h1E, 32'h0);
    check("lh_rdata", o_rd, 32'hFFFF8001);
    xact(1'b0, 2'b01, 1'b1, 32'h1E, 32'h0);
    check("lhu_rdata", o_rd, 32'h00008001);

    // Misaligned word store
    xact(1'b1, 2'b10, 1'b0, 32'h04, 32'h11223344);
    xact(1'b1, 2'b10, 1'b0, 32'h05, 32'hAABBCCDD);
`ifdef MEM_MISALIGN_TRAP_EN
    check("sw_mis_exc", {31'd0, o_exc}, 32'd1);
    check("sw_mis_we", {31'd0, o_we}, 32'd0);
    check("sw_mis_rdata", o_rd, 32'h0);
    xact(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    check("lw_after_mis", o_rd, 32'h11223344);
    xact(1'b0, 2'b01, 1'b0, 32'h1F, 32'h0);
    check("lh_mis_exc", {31'd0, o_exc}, 32'd1);
    check("lh_mis_rdata", o_rd, 32'h0);
`else
    check("sw_mis_exc", {31'd0, o_exc}, 32'd0);
    check("sw_mis_we", {31'd0, o_we}, 32'd1);
    check("sw_mis_sel", {28'd0, o_sel}, 32'hF);
    xact(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    check("lw_after_mis", o_rd, 32'hAABBCCDD);
    xact(1'b0, 2'b01, 1'b0, 32'h1F, 32'h0);
    check("lh_mis_exc", {31'd0, o_exc}, 32'd0);
    check("lh_mis_rdata", o_rd, 32'hFFFF8001);
`endif

    // Address wrap modulo 128 bytes
    xact(1'b1, 2'b10, 1'b0, 32'h84, 32'h5A5A5A5A);
    xact(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    check("wrap_lw", o_rd, 32'h5A5A5A5A);

    // Response back-pressure with a competing request pending
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h08;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h0C; req_wdata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, 32'hF0ADBEEF);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    check("bp_idle_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_sw_we", {31'd0, ram_we}, 32'd1);
    check("bp_sw_addr", {27'd0, ram_addr}, 32'd3);
    @(negedge clk);
    xact(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    check("bp_lw", o_rd, 32'h12345678);

    // Reset during ACCESS aborts the store
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h0BADC0DE);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_acc_we", {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    check("rst_acc_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_acc_ready", {31'd0, req_ready}, 32'd1);
    check("rst_acc_rdata", resp_rdata, 32'h0);
    rst_n = 1'b1;
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("rst_acc_word", o_rd, 32'h0BADC0DE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
